// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared defaults and packed half-period lookup for the CPU clock switch
package cpu_clk_pkg;
  localparam int HP_MAX_W = 2048;
  localparam logic [31:0] DEF_HALF_PERIODS = 32'h07_04_02_01;
  localparam int DEF_DEBOUNCE_CYCLES = 2000000;
  typedef logic [HP_MAX_W-1:0] hp_vec_t;
  function automatic logic [7:0] get_half(input hp_vec_t hp, input int unsigned mode);
    logic [7:0] h;
    h = hp[8*mode +: 8];
    return (h == 8'd0) ? 8'd1 : h;
  endfunction
endpackage

// File: rtl/cpu_clk_switch_sel_debounce.sv
// sel_debounce: 2-FF synchronised selector with stability counter and range flag
module sel_debounce #(
  parameter int W = 2,
  parameter int NUM_MODES = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic [W-1:0] RESET_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sel_i,
  output logic [W-1:0] stable_o,
  output logic         err_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [W-1:0] s1_q, s2_q, cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic in_range;
  assign in_range = 32'(cand_q) < NUM_MODES;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q     <= RESET_VAL;
      s2_q     <= RESET_VAL;
      cand_q   <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sel_i;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  // out-of-range candidates never count, so they can never reach stable
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q && in_range) begin
      stable_d = (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? cand_q : stable_q;
      cnt_d    = (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
    end
  end
  assign stable_o = stable_q;
  assign err_o    = !in_range;
endmodule

// File: rtl/cpu_clk_switch.sv
// cpu_clk_switch: runt-free multi-speed CPU clock from C100M, retimed only when the bus is idle.
// Define CPU_SPEED_LOCK_EN to add a LOCK input that holds off speed commits.
module cpu_clk_switch
  import cpu_clk_pkg::*;
#(
  parameter int NUM_MODES = 4,
  parameter logic [8*NUM_MODES-1:0] HALF_PERIODS = (8*NUM_MODES)'(DEF_HALF_PERIODS),
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RESET_MODE = NUM_MODES - 1
) (
  input  logic                         C100M,
  input  logic                         RESET,
`ifdef CPU_SPEED_LOCK_EN
  input  logic                         LOCK,
`endif
  input  logic [$clog2(NUM_MODES)-1:0] SPEED_SEL,
  input  logic                         AS_CPU_n,
  input  logic                         DTACK_CPU_n,
  output logic                         CLK_OUT,
  output logic                         CLK_RISE,
  output logic [$clog2(NUM_MODES)-1:0] ACTIVE_MODE,
  output logic                         SWITCH_PENDING,
  output logic                         SWITCH_STROBE,
  output logic                         SEL_ERR
);
  localparam int MODE_W = $clog2(NUM_MODES);
  localparam hp_vec_t HP = hp_vec_t'(HALF_PERIODS);
  localparam logic [MODE_W-1:0] RST_MODE = MODE_W'(RESET_MODE);
  logic as_s1_q, as_q, dt_s1_q, dt_q, lock;
  logic [7:0] phase_q, phase_d, half;
  logic clk_q, clk_d, rise_q, rise_d, pend_q, pend_d, strobe_q, strobe_d;
  logic [MODE_W-1:0] active_q, active_d, stable;
  logic last, commit;
`ifdef CPU_SPEED_LOCK_EN
  logic lk_s1_q, lk_q;
  always_ff @(posedge C100M or posedge RESET)
    if (RESET) {lk_s1_q, lk_q} <= 2'b00;
    else {lk_s1_q, lk_q} <= {LOCK, lk_s1_q};
  assign lock = lk_q;
`else
  assign lock = 1'b0;
`endif
  sel_debounce #(
    .W(MODE_W),
    .NUM_MODES(NUM_MODES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL(RST_MODE)
  ) u_deb (
    .clk(C100M),
    .rst(RESET),
    .sel_i(SPEED_SEL),
    .stable_o(stable),
    .err_o(SEL_ERR)
  );
  assign half = get_half(HP, 32'(active_q));
  // a mode change lands only on the last low cycle, so the rising edge starts a full new-rate phase
  always_comb begin
    last     = phase_q == half - 8'd1;
    commit   = pend_q && !clk_q && last && as_q && dt_q && !lock;
    phase_d  = last ? 8'd0 : phase_q + 8'd1;
    clk_d    = clk_q ^ last;
    rise_d   = last && !clk_q;
    active_d = commit ? stable : active_q;
    strobe_d = commit;
    pend_d   = stable != active_d;
  end
  always_ff @(posedge C100M or posedge RESET)
    if (RESET) begin
      as_s1_q  <= 1'b1;
      as_q     <= 1'b1;
      dt_s1_q  <= 1'b1;
      dt_q     <= 1'b1;
      phase_q  <= 8'd0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      active_q <= RST_MODE;
      pend_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      as_s1_q  <= AS_CPU_n;
      as_q     <= as_s1_q;
      dt_s1_q  <= DTACK_CPU_n;
      dt_q     <= dt_s1_q;
      phase_q  <= phase_d;
      clk_q    <= clk_d;
      rise_q   <= rise_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
    end
  assign CLK_OUT        = clk_q;
  assign CLK_RISE       = rise_q;
  assign ACTIVE_MODE    = active_q;
  assign SWITCH_PENDING = pend_q;
  assign SWITCH_STROBE  = strobe_q;
endmodule

// File: tb/tb_cpu_clk_switch.sv
// tb_cpu_clk_switch: scoreboard bench for a 4-mode and a 3-mode cpu_clk_switch
module tb_cpu_clk_switch;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] sel = 2'd3, sel_b = 2'd0;
  logic as_n = 1'b1, dt_n = 1'b1;
  logic clk_o, rise, pend, strobe, err;
  logic [1:0] mode;
  logic clk_b, rise_b, pend_b, strobe_b, err_b;
  logic [1:0] mode_b;
`ifdef CPU_SPEED_LOCK_EN
  logic lock = 1'b0;
`endif
  int passed = 0, total = 0, strobes = 0;
  int exp_q[$];
  cpu_clk_switch #(.DEBOUNCE_CYCLES(16)) dut (
    .C100M(clk), .RESET(rst),
`ifdef CPU_SPEED_LOCK_EN
    .LOCK(lock),
`endif
    .SPEED_SEL(sel), .AS_CPU_n(as_n), .DTACK_CPU_n(dt_n),
    .CLK_OUT(clk_o), .CLK_RISE(rise), .ACTIVE_MODE(mode),
    .SWITCH_PENDING(pend), .SWITCH_STROBE(strobe), .SEL_ERR(err)
  );
  cpu_clk_switch #(.NUM_MODES(3), .HALF_PERIODS(24'h04_02_01), .DEBOUNCE_CYCLES(16), .RESET_MODE(0)) dut_b (
    .C100M(clk), .RESET(rst),
`ifdef CPU_SPEED_LOCK_EN
    .LOCK(1'b0),
`endif
    .SPEED_SEL(sel_b), .AS_CPU_n(1'b1), .DTACK_CPU_n(1'b1),
    .CLK_OUT(clk_b), .CLK_RISE(rise_b), .ACTIVE_MODE(mode_b),
    .SWITCH_PENDING(pend_b), .SWITCH_STROBE(strobe_b), .SEL_ERR(err_b)
  );
  function automatic int half_of(input int m);
    return m == 0 ? 1 : m == 1 ? 2 : m == 2 ? 4 : 7;
  endfunction
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_strobe(input string name, input int bound);
    int n = 0;
    while (!strobe && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(strobe), 1);
  endtask
  // monitor: pops expected commits on each strobe and times every clock phase
  logic prev = 1'b0;
  int run = 0, run_mode = 0;
  bit skip = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      skip = 1'b1;
      run = 0;
      prev = clk_o;
    end else begin
      if (strobe) begin
        strobes++;
        if (exp_q.size() == 0) check("strobe_unexpected", int'(strobe), 0);
        else check("strobe_mode", int'(mode), exp_q.pop_front());
      end
      if (clk_o != prev) begin
        if (!skip) check("phase_len", run, half_of(run_mode));
        check("rise_on_edge", int'(rise), int'(clk_o));
        skip = 1'b0;
        run = 1;
        run_mode = int'(mode);
        prev = clk_o;
      end else begin
        run++;
        if (rise) check("rise_spurious", int'(rise), 0);
      end
    end
  end
  initial begin
    int seen, n, s0;
    cycles(3);
    check("rst_clk", int'(clk_o), 0);
    check("rst_rise", int'(rise), 0);
    check("rst_mode", int'(mode), 3);
    check("rst_pend", int'(pend), 0);
    check("rst_strobe", int'(strobe), 0);
    check("rst_err", int'(err), 0);
    check("rst_mode_b", int'(mode_b), 0);
    rst = 1'b0;
    cycles(60);
    check("m3_mode", int'(mode), 3);
    check("m3_no_strobe", strobes, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      sel = i[0] ? 2'd3 : 2'd1;
      repeat (10) begin
        @(negedge clk);
        seen = seen | int'(pend);
      end
    end
    cycles(30);
    check("bounce_pend", seen, 0);
    check("bounce_mode", int'(mode), 3);
    check("bounce_no_strobe", strobes, 0);
    sel = 2'd0;
    exp_q.push_back(0);
    n = 0;
    while (!pend && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("deb_latency", n, 20);
    wait_strobe("to0_strobe", 30);
    check("to0_mode", int'(mode), 0);
    check("to0_pend", int'(pend), 0);
    cycles(20);
    n = 0;
    while (!clk_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("m0_high_seen", int'(clk_o), 1);
    rst = 1'b1;
    #1;
    check("arst_clk", int'(clk_o), 0);
    check("arst_mode", int'(mode), 3);
    check("arst_pend", int'(pend), 0);
    check("arst_rise", int'(rise), 0);
    sel = 2'd3;
    cycles(3);
    rst = 1'b0;
    cycles(10);
    s0 = strobes;
    as_n = 1'b0;
    dt_n = 1'b0;
    sel = 2'd1;
    cycles(200);
    check("busy_pend", int'(pend), 1);
    check("busy_mode", int'(mode), 3);
    as_n = 1'b1;
    cycles(30);
    check("dtack_pend", int'(pend), 1);
    check("dtack_mode", int'(mode), 3);
    check("busy_no_strobe", strobes, s0);
    dt_n = 1'b1;
    exp_q.push_back(1);
    wait_strobe("to1_strobe", 20);
    check("to1_mode", int'(mode), 1);
    cycles(30);
    s0 = strobes;
    as_n = 1'b0;
    sel = 2'd2;
    cycles(25);
    check("ret_pend_set", int'(pend), 1);
    sel = 2'd1;
    cycles(25);
    check("ret_pend_clr", int'(pend), 0);
    as_n = 1'b1;
    cycles(40);
    check("ret_no_strobe", strobes, s0);
    check("ret_mode", int'(mode), 1);
`ifdef CPU_SPEED_LOCK_EN
    s0 = strobes;
    lock = 1'b1;
    sel = 2'd0;
    cycles(40);
    check("lock_pend", int'(pend), 1);
    check("lock_mode", int'(mode), 1);
    check("lock_no_strobe", strobes, s0);
    lock = 1'b0;
    exp_q.push_back(0);
    wait_strobe("unlock_strobe", 20);
    check("unlock_mode", int'(mode), 0);
`endif
    sel_b = 2'd3;
    cycles(5);
    check("b_err_set", int'(err_b), 1);
    cycles(40);
    check("b_err_mode", int'(mode_b), 0);
    check("b_err_pend", int'(pend_b), 0);
    check("b_err_held", int'(err_b), 1);
    sel_b = 2'd2;
    cycles(5);
    check("b_err_clr", int'(err_b), 0);
    n = 0;
    while (!strobe_b && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b_strobe", int'(strobe_b), 1);
    check("b_mode", int'(mode_b), 2);
    cycles(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
